// File: rtl/result_stream_arbiter.sv
// Packet arbiter sharing one registered result stream among CORES cores.
// Define SRC_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed lowest-index priority.
module result_stream_arbiter #(
    parameter int CORES  = 4,
    parameter int DATA_W = 512
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CORES-1:0]            core_req,
    input  logic [CORES-1:0]            core_valid,
    input  logic [CORES-1:0]            core_sop,
    input  logic [CORES-1:0]            core_eop,
    input  logic [CORES*DATA_W-1:0]     core_data,
    output logic [CORES-1:0]            core_ready,
    output logic                        grant_valid,
    output logic [$clog2(CORES)-1:0]    grant_id,
    output logic [DATA_W-1:0]           src_data,
    output logic                        src_valid,
    output logic                        src_sop,
    output logic                        src_eop,
    input  logic                        src_ready,
    output logic                        proto_err
);

    localparam int ID_W = $clog2(CORES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic              first_beat;
    logic              slot_free;
    logic              accept;
    logic              sel_valid;
    logic              sel_sop;
    logic              sel_eop;
    logic [DATA_W-1:0] sel_data;
    logic [ID_W-1:0]   winner;

`ifdef SRC_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]   rr_ptr;
`endif

    assign slot_free = !src_valid || src_ready;
    assign sel_valid = core_valid[grant_id];
    assign sel_sop   = core_sop[grant_id];
    assign sel_eop   = core_eop[grant_id];
    assign accept    = (state == BUSY) && sel_valid && slot_free;

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < CORES; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_data = core_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        core_ready = '0;
        if (state == BUSY) begin
            core_ready[grant_id] = slot_free;
        end
    end

`ifdef SRC_ARB_ROUND_ROBIN_EN
    // Search starts at rr_ptr and wraps, so a lone requester always wins.
    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < CORES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= CORES) begin
                idx = idx - CORES;
            end
            if (!found && core_req[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = CORES - 1; i >= 0; i--) begin
            if (core_req[i]) begin
                winner = ID_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            src_data    <= '0;
            src_valid   <= 1'b0;
            src_sop     <= 1'b0;
            src_eop     <= 1'b0;
            proto_err   <= 1'b0;
            first_beat  <= 1'b0;
`ifdef SRC_ARB_ROUND_ROBIN_EN
            rr_ptr      <= '0;
`endif
        end else begin
            if (accept) begin
                src_data   <= sel_data;
                src_eop    <= sel_eop;
                src_valid  <= 1'b1;
                // A missing leading sop is repaired so downstream still sees a framed packet.
                src_sop    <= sel_sop | first_beat;
                first_beat <= 1'b0;
                if (sel_sop != first_beat) begin
                    proto_err <= 1'b1;
                end
            end else if (src_ready) begin
                src_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|core_req) begin
                        grant_id    <= winner;
                        grant_valid <= 1'b1;
                        first_beat  <= 1'b1;
                        state       <= BUSY;
`ifdef SRC_ARB_ROUND_ROBIN_EN
                        rr_ptr      <= (winner == ID_W'(CORES - 1)) ? '0 : winner + 1'b1;
`endif
                    end
                end
                BUSY: begin
                    if (accept && sel_eop) begin
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_stream_arbiter.sv
// Scoreboard bench for result_stream_arbiter: per-core packet queues drive the cores,
// expected beats are queued in predicted grant order and checked as the stream drains.
module tb_result_stream_arbiter;

    localparam int CORES = 4;
    localparam int DW    = 512;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [CORES-1:0]     core_req = '0;
    logic [CORES-1:0]     core_valid = '0;
    logic [CORES-1:0]     core_sop = '0;
    logic [CORES-1:0]     core_eop = '0;
    logic [CORES*DW-1:0]  core_data = '0;
    logic [CORES-1:0]     core_ready;
    logic                 grant_valid;
    logic [1:0]           grant_id;
    logic [DW-1:0]        src_data;
    logic                 src_valid;
    logic                 src_sop;
    logic                 src_eop;
    logic                 src_ready = 1'b1;
    logic                 proto_err;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    stall_left = 0;
    bit    flush = 1'b0;
    bit    prev_gv = 1'b0;
    logic [CORES-1:0] fired = '0;

    beat_t cq [CORES][$];
    beat_t sb [$];
    int    out_cyc [$];
    int    grants [$];

    result_stream_arbiter #(.CORES(CORES), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_valid(core_valid), .core_sop(core_sop),
        .core_eop(core_eop), .core_data(core_data), .core_ready(core_ready),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop),
        .src_eop(src_eop), .src_ready(src_ready), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Core models, downstream sink and output monitor all run on the falling edge.
    always @(negedge clk) begin
        beat_t e;
        cyc = cyc + 1;
        if (flush) begin
            for (int i = 0; i < CORES; i++) cq[i].delete();
            sb.delete();
            fired = '0;
            flush = 1'b0;
        end
        for (int i = 0; i < CORES; i++) begin
            if (fired[i] && cq[i].size() > 0) void'(cq[i].pop_front());
        end
        if (stall_left > 0) begin
            src_ready  = 1'b0;
            stall_left = stall_left - 1;
        end else begin
            src_ready = 1'b1;
        end
        for (int i = 0; i < CORES; i++) begin
            if (cq[i].size() > 0) begin
                core_req[i]             = 1'b1;
                core_valid[i]           = 1'b1;
                core_sop[i]             = cq[i][0].sop;
                core_eop[i]             = cq[i][0].eop;
                core_data[i*DW +: DW]   = cq[i][0].data;
            end else begin
                core_req[i]             = 1'b0;
                core_valid[i]           = 1'b0;
                core_sop[i]             = 1'b0;
                core_eop[i]             = 1'b0;
                core_data[i*DW +: DW]   = '0;
            end
        end
        #1;
        fired = core_valid & core_ready;
        if (src_valid && src_ready) begin
            checks = checks + 1;
            out_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("[TB] FAIL unexpected_beat: got data=%h sop=%b eop=%b, required no beat",
                         src_data[63:0], src_sop, src_eop);
            end else begin
                e = sb.pop_front();
                if (src_data !== e.data || src_sop !== e.sop || src_eop !== e.eop) begin
                    errors = errors + 1;
                    $display("[TB] FAIL beat: got data=%h sop=%b eop=%b, required data=%h sop=%b eop=%b",
                             src_data[63:0], src_sop, src_eop, e.data[63:0], e.sop, e.eop);
                end
            end
        end
        if (grant_valid && !prev_gv) grants.push_back(int'(grant_id));
        prev_gv = grant_valid;
    end

    function automatic logic [DW-1:0] mk_data(input int core, input int idx);
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
        d[15:0] = {8'(core), 8'(idx)};
        return d;
    endfunction

    task automatic push_beat(input int core, input logic [DW-1:0] d, input logic sop,
                             input logic eop, input logic exp_sop);
        beat_t b;
        beat_t e;
        b.data = d; b.sop = sop;     b.eop = eop;
        e.data = d; e.sop = exp_sop; e.eop = eop;
        cq[core].push_back(b);
        sb.push_back(e);
    endtask

    task automatic push_packet(input int core, input int len);
        logic [DW-1:0] d;
        for (int i = 0; i < len; i++) begin
            d = mk_data(core, i);
            push_beat(core, d, i == 0, i == len - 1, i == 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        reset = 1'b1;
        flush = 1'b1;
        stall_left = 0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        grants.delete();
        out_cyc.delete();
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && sb.size() != 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        do_reset();
        checks = checks + 4;
        if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin
            errors = errors + 1;
            $display("[TB] FAIL reset_grant: got gv=%b id=%0d, required gv=0 id=0", grant_valid, grant_id);
        end
        if (src_valid !== 1'b0 || src_sop !== 1'b0 || src_eop !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL reset_src: got v=%b sop=%b eop=%b, required 0 0 0", src_valid, src_sop, src_eop);
        end
        if (src_data !== '0) begin
            errors = errors + 1;
            $display("[TB] FAIL reset_data: got %h, required 0", src_data[63:0]);
        end
        if (proto_err !== 1'b0 || core_ready !== 4'b0000) begin
            errors = errors + 1;
            $display("[TB] FAIL reset_misc: got perr=%b ready=%b, required 0 0000", proto_err, core_ready);
        end
    endtask

    task automatic test_single_core();
        do_reset();
        push_packet(2, 3);
        @(negedge clk); #2;
        @(negedge clk); #2;
        checks = checks + 2;
        if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin
            errors = errors + 1;
            $display("[TB] FAIL single_grant: got gv=%b id=%0d, required gv=1 id=2", grant_valid, grant_id);
        end
        if (core_ready !== 4'b0100) begin
            errors = errors + 1;
            $display("[TB] FAIL single_ready: got %b, required 0100", core_ready);
        end
        @(negedge clk); #2;
        checks = checks + 1;
        if (src_valid !== 1'b1 || src_sop !== 1'b1 || src_eop !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL single_d0: got v=%b sop=%b eop=%b, required 1 1 0", src_valid, src_sop, src_eop);
        end
        @(negedge clk); #2;
        checks = checks + 1;
        if (src_valid !== 1'b1 || src_sop !== 1'b0 || src_eop !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL single_d1: got v=%b sop=%b eop=%b, required 1 0 0", src_valid, src_sop, src_eop);
        end
        @(negedge clk); #2;
        checks = checks + 1;
        if (src_valid !== 1'b1 || src_eop !== 1'b1 || grant_valid !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL single_d2: got v=%b eop=%b gv=%b, required 1 1 0", src_valid, src_eop, grant_valid);
        end
        drain();
        checks = checks + 1;
        if (sb.size() != 0 || out_cyc.size() != 3) begin
            errors = errors + 1;
            $display("[TB] FAIL single_drain: got pending=%0d out=%0d, required 0 3", sb.size(), out_cyc.size());
        end
    endtask

    task automatic test_contention();
        do_reset();
        push_packet(1, 2);
        push_packet(3, 2);
        drain();
        checks = checks + 1;
        if (out_cyc.size() != 4) begin
            errors = errors + 1;
            $display("[TB] FAIL contention_count: got %0d beats, required 4", out_cyc.size());
        end else begin
            checks = checks + 1;
            if (out_cyc[1] - out_cyc[0] != 1 || out_cyc[2] - out_cyc[1] != 2 || out_cyc[3] - out_cyc[2] != 1) begin
                errors = errors + 1;
                $display("[TB] FAIL contention_spacing: got gaps %0d %0d %0d, required 1 2 1",
                         out_cyc[1] - out_cyc[0], out_cyc[2] - out_cyc[1], out_cyc[3] - out_cyc[2]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] held;
        logic          held_sop;
        logic          held_eop;
        do_reset();
        push_packet(0, 5);
        repeat (4) @(negedge clk);
        #2;
        stall_left = 4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #2;
            if (k == 0) begin
                held = src_data; held_sop = src_sop; held_eop = src_eop;
            end
            checks = checks + 1;
            if (src_valid !== 1'b1 || src_data !== held || src_sop !== held_sop ||
                src_eop !== held_eop || core_ready !== 4'b0000 || src_ready !== 1'b0) begin
                errors = errors + 1;
                $display("[TB] FAIL backpressure_hold: got v=%b data=%h ready=%b, required v=1 data=%h ready=0000",
                         src_valid, src_data[63:0], core_ready, held[63:0]);
            end
        end
        drain();
        checks = checks + 1;
        if (sb.size() != 0 || out_cyc.size() != 5) begin
            errors = errors + 1;
            $display("[TB] FAIL backpressure_count: got pending=%0d out=%0d, required 0 5", sb.size(), out_cyc.size());
        end
    endtask

    task automatic test_round_robin();
        int exp_order [5];
        logic [DW-1:0] d;
        do_reset();
`ifdef SRC_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3, 0};
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < CORES; c++) begin
                d = mk_data(c, p);
                push_beat(c, d, 1'b1, 1'b1, 1'b1);
            end
        end
`else
        exp_order = '{0, 0, 1, 1, 2};
        for (int c = 0; c < CORES; c++) begin
            for (int p = 0; p < 2; p++) begin
                d = mk_data(c, p);
                push_beat(c, d, 1'b1, 1'b1, 1'b1);
            end
        end
`endif
        drain();
        for (int k = 0; k < 5; k++) begin
            checks = checks + 1;
            if (grants.size() <= k) begin
                errors = errors + 1;
                $display("[TB] FAIL rr_order[%0d]: got no grant, required %0d", k, exp_order[k]);
            end else if (grants[k] != exp_order[k]) begin
                errors = errors + 1;
                $display("[TB] FAIL rr_order[%0d]: got %0d, required %0d", k, grants[k], exp_order[k]);
            end
        end
    endtask

    task automatic test_protocol();
        logic [DW-1:0] d;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d = mk_data(1, i);
            push_beat(1, d, 1'b0, i == 2, i == 0);
        end
        @(negedge clk); #2;
        @(negedge clk); #2;
        checks = checks + 1;
        if (proto_err !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL proto_before: got %b, required 0", proto_err);
        end
        @(negedge clk); #2;
        checks = checks + 1;
        if (proto_err !== 1'b1 || src_valid !== 1'b1 || src_sop !== 1'b1) begin
            errors = errors + 1;
            $display("[TB] FAIL proto_first: got perr=%b v=%b sop=%b, required 1 1 1", proto_err, src_valid, src_sop);
        end
        drain();
        repeat (4) @(negedge clk);
        #2;
        checks = checks + 1;
        if (proto_err !== 1'b1) begin
            errors = errors + 1;
            $display("[TB] FAIL proto_sticky: got %b, required 1", proto_err);
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d = mk_data(2, i);
            push_beat(2, d, i < 2, i == 2, i < 2);
        end
        repeat (3) @(negedge clk);
        #2;
        checks = checks + 1;
        if (proto_err !== 1'b0) begin
            errors = errors + 1;
            $display("[TB] FAIL proto_clean_first: got %b, required 0", proto_err);
        end
        @(negedge clk); #2;
        checks = checks + 1;
        if (proto_err !== 1'b1 || src_sop !== 1'b1) begin
            errors = errors + 1;
            $display("[TB] FAIL proto_mid_sop: got perr=%b sop=%b, required 1 1", proto_err, src_sop);
        end
        drain();
    endtask

    task automatic test_reset_mid_packet();
        logic [DW-1:0] d;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            d = mk_data(3, i);
            push_beat(3, d, 1'b0, i == 4, i == 0);
        end
        repeat (4) @(negedge clk);
        #2;
        checks = checks + 1;
        if (proto_err !== 1'b1 || grant_valid !== 1'b1) begin
            errors = errors + 1;
            $display("[TB] FAIL midreset_pre: got perr=%b gv=%b, required 1 1", proto_err, grant_valid);
        end
        reset = 1'b1;
        flush = 1'b1;
        @(negedge clk); #2;
        checks = checks + 1;
        if (src_valid !== 1'b0 || grant_valid !== 1'b0 || proto_err !== 1'b0 || core_ready !== 4'b0000) begin
            errors = errors + 1;
            $display("[TB] FAIL midreset_post: got v=%b gv=%b perr=%b ready=%b, required 0 0 0 0000",
                     src_valid, grant_valid, proto_err, core_ready);
        end
        reset = 1'b0;
        push_packet(2, 1);
        @(negedge clk); #2;
        @(negedge clk); #2;
        checks = checks + 1;
        if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin
            errors = errors + 1;
            $display("[TB] FAIL midreset_regrant: got gv=%b id=%0d, required 1 2", grant_valid, grant_id);
        end
        drain();
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL midreset_drain: got pending=%0d, required 0", sb.size());
        end
    endtask

    initial begin
        $display("[TB] result_stream_arbiter bench start");
        test_reset();
        test_single_core();
        test_contention();
        test_backpressure();
        test_round_robin();
        test_protocol();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
